// File: rtl/half_adder_pkg.sv
// Shared definitions for the half-adder slice: default sizes, the per-lane
// result record and the single-lane evaluation function.
package half_adder_pkg;

    localparam int HA_WIDTH_DEF = 1;
    localparam int HA_CNT_W_DEF = 8;

    // Result of one half-adder lane.
    typedef struct packed {
        logic sum;
        logic carry;
    } ha_lane_t;

    // Bitwise operators keep X/Z on an input visible as X on the outputs.
    function automatic ha_lane_t ha_eval(input logic a, input logic b);
        ha_lane_t r;
        r.sum   = a ^ b;
        r.carry = a & b;
        return r;
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// One-bit combinational half adder. It has no clock, no reset and no state.
module half_adder_cell
    import half_adder_pkg::*;
(
    input  logic     a,
    input  logic     b,
    output ha_lane_t lane
);

    assign lane = ha_eval(a, b);

endmodule

// File: rtl/half_adder_behavioural.sv
// Bit-parallel half adder: WIDTH independent lanes plus a saturating count
// of clock edges on which any lane produced a carry.
//
// Build option HALF_ADDER_REG_OUT_EN: when defined, sum/carry are taken from
// flops (one cycle latency, async-cleared by rst). When undefined, sum/carry
// are purely combinational and need neither clk nor rst.
//
// The carry counter always samples the combinational carry. With the output
// register enabled it therefore counts the same inputs the register captures
// on that edge.
module half_adder_behavioural
    import half_adder_pkg::*;
#(
    parameter int WIDTH = HA_WIDTH_DEF,
    parameter int CNT_W = HA_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [CNT_W-1:0] carry_cnt
);

    logic [WIDTH-1:0] sum_int;
    logic [WIDTH-1:0] carry_int;

    // One cell per lane. There is no carry chain between lanes.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ha_lane_t lane;

        half_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .lane (lane)
        );

        assign sum_int[i]   = lane.sum;
        assign carry_int[i] = lane.carry;
    end

`ifdef HALF_ADDER_REG_OUT_EN
    // Registered outputs: capture the lane results on each rising clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= '0;
            carry <= '0;
        end else begin
            sum   <= sum_int;
            carry <= carry_int;
        end
    end
`else
    // Combinational outputs: follow a/b in the same timestep.
    assign sum   = sum_int;
    assign carry = carry_int;
`endif

    // Carry-event counter. It increments on edges with any carry and holds
    // at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_cnt <= '0;
        end else if ((|carry_int) && (carry_cnt != {CNT_W{1'b1}})) begin
            carry_cnt <= carry_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_half_adder_behavioural.sv
// Testbench for half_adder_behavioural. The driver issues directed vectors
// and pushes hand-computed expectations. A separate monitor pops them and
// compares them with the DUT outputs at each sample point.
// The bench adapts to HALF_ADDER_REG_OUT_EN when that macro is defined.
`timescale 1ns/1ps
module tb_half_adder_behavioural;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_idle = 1'b0;
    logic rst_idle = 1'b0;

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUT instances ----------------
    // u1: WIDTH=1 with its clk/rst held idle (combinational path only)
    logic       a1, b1;
    logic       sum1, carry1;
    logic [7:0] cnt1;

    half_adder_behavioural #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk(clk_idle), .rst(rst_idle), .a(a1), .b(b1),
        .sum(sum1), .carry(carry1), .carry_cnt(cnt1)
    );

    // u4: WIDTH=4 for lane independence, the counter and the output register
    logic [3:0] a4 = 4'b1100;
    logic [3:0] b4 = 4'b1010;
    logic [3:0] sum4, carry4;
    logic [7:0] cnt4;

    half_adder_behavioural #(.WIDTH(4), .CNT_W(8)) u4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4),
        .sum(sum4), .carry(carry4), .carry_cnt(cnt4)
    );

    // u2: CNT_W=2 for saturation
    logic       a2 = 1'b0;
    logic       b2 = 1'b0;
    logic       sum2, carry2;
    logic [1:0] cnt2;

    half_adder_behavioural #(.WIDTH(1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .a(a2), .b(b2),
        .sum(sum2), .carry(carry2), .carry_cnt(cnt2)
    );

    // ---------------- scoreboard ----------------
    localparam int T_U1 = 0;  // {sum1, carry1}
    localparam int T_S4 = 1;  // sum4
    localparam int T_C4 = 2;  // carry4
    localparam int T_N4 = 3;  // cnt4
    localparam int T_N2 = 4;  // cnt2

    logic [7:0] exp_q[$];
    int         tag_q[$];
    string      name_q[$];
    event       chk_ev;
    int         n_cmp = 0;
    int         n_bad = 0;

    // Driver side: queue one expectation and wake the monitor.
    task automatic expect_val(input int tag, input string name, input logic [7:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        name_q.push_back(name);
        -> chk_ev;
    endtask

    // Monitor: drain all pending expectations against the current outputs.
    initial begin
        forever begin
            @(chk_ev);
            while (exp_q.size() > 0) begin
                logic [7:0] e;
                logic [7:0] act;
                int         t;
                string      nm;
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                nm  = name_q.pop_front();
                act = 8'h00;
                case (t)
                    T_U1:    act = {6'b0, sum1, carry1};
                    T_S4:    act = {4'b0, sum4};
                    T_C4:    act = {4'b0, carry4};
                    T_N4:    act = cnt4;
                    default: act = {6'b0, cnt2};
                endcase
                n_cmp++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL %s: got %b expected %b at %0t", nm, act, e, $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step_u1(input logic ai, input logic bi, input logic [1:0] exp_sc,
                           input string nm);
        a1 = ai;
        b1 = bi;
        #0.5;
        expect_val(T_U1, nm, {6'b0, exp_sc});
        #0.5;
    endtask

    task automatic edge_then_sample();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
`ifndef HALF_ADDER_REG_OUT_EN
        // Before any stimulus u1 outputs read X.
        #0.5;
        expect_val(T_U1, "u1_initial_x", 8'b0000_00xx);
        #0.5;
        // Truth table walk at 1-unit steps; outputs are {sum, carry}.
        step_u1(1'b0, 1'b0, 2'b00, "u1_00");
        step_u1(1'b0, 1'b1, 2'b10, "u1_01");
        step_u1(1'b1, 1'b0, 2'b10, "u1_10");
        step_u1(1'b1, 1'b1, 2'b01, "u1_11");
        step_u1(1'b0, 1'b0, 2'b00, "u1_back_00");
`endif

        // During reset (rst high since time 0).
        @(negedge clk);
`ifdef HALF_ADDER_REG_OUT_EN
        expect_val(T_S4, "reg_sum_in_rst", 8'h00);
        expect_val(T_C4, "reg_carry_in_rst", 8'h00);
`else
        // rst does not touch the combinational path; no inter-lane carry.
        expect_val(T_S4, "w4_sum_1100_1010", 8'b0000_0110);
        expect_val(T_C4, "w4_carry_1100_1010", 8'b0000_1000);
`endif
        expect_val(T_N4, "cnt4_in_rst", 8'd0);
        expect_val(T_N2, "cnt2_in_rst", 8'd0);

`ifdef HALF_ADDER_REG_OUT_EN
        // Release reset with lane 0 carrying; outputs stay 0 until the edge.
        rst = 1'b0;
        a4  = 4'b0001;
        b4  = 4'b0001;
        #1;
        expect_val(T_S4, "reg_sum_before_edge", 8'h00);
        expect_val(T_C4, "reg_carry_before_edge", 8'h00);
        @(posedge clk);
        #1;
        expect_val(T_S4, "reg_sum_after_edge", 8'h00);
        expect_val(T_C4, "reg_carry_after_edge", 8'h01);
        // Mid-cycle input change is not visible until the following edge.
        #2;
        a4 = 4'b0000;
        #1;
        expect_val(T_S4, "reg_sum_hold_midcycle", 8'h00);
        expect_val(T_C4, "reg_carry_hold_midcycle", 8'h01);
        @(posedge clk);
        #1;
        expect_val(T_S4, "reg_sum_next_edge", 8'h01);
        expect_val(T_C4, "reg_carry_next_edge", 8'h00);
        expect_val(T_N4, "reg_cnt4_one_carry_edge", 8'd1);
        // Return to reset for the counter section.
        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_val(T_N4, "cnt4_async_clear_a", 8'd0);
`endif

        // Counter: 5 carry edges, then 3 idle edges on u4; u2 carries on all 8.
        @(negedge clk);
        rst = 1'b0;
        a4  = 4'b0001;
        b4  = 4'b0001;
        a2  = 1'b1;
        b2  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            edge_then_sample();
            if (i == 2) expect_val(T_N2, "cnt2_after_2", 8'd2);
            if (i == 3) expect_val(T_N2, "cnt2_after_3_sat", 8'd3);
        end
        expect_val(T_N4, "cnt4_after_5_carry", 8'd5);
        a4 = 4'b0000;
        b4 = 4'b0000;
        for (int i = 0; i < 3; i++) edge_then_sample();
        expect_val(T_N4, "cnt4_hold_no_carry", 8'd5);
        expect_val(T_N2, "cnt2_stays_sat", 8'd3);

        // Reset between edges clears immediately and holds while high.
        a4 = 4'b1111;
        b4 = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        expect_val(T_N4, "cnt4_async_clear_b", 8'd0);
        expect_val(T_N2, "cnt2_async_clear", 8'd0);
        edge_then_sample();
        expect_val(T_N4, "cnt4_held_in_rst", 8'd0);

        // First increment comes on the first edge after release.
        rst = 1'b0;
        edge_then_sample();
        expect_val(T_N4, "cnt4_first_after_rst", 8'd1);

        // Complementary inputs: all sums, no carry, counter holds.
        a4 = 4'b0101;
        b4 = 4'b1010;
`ifndef HALF_ADDER_REG_OUT_EN
        #1;
        expect_val(T_S4, "w4_sum_0101_1010", 8'b0000_1111);
        expect_val(T_C4, "w4_carry_0101_1010", 8'b0000_0000);
`endif
        edge_then_sample();
        expect_val(T_N4, "cnt4_no_carry_hold", 8'd1);
`ifdef HALF_ADDER_REG_OUT_EN
        expect_val(T_S4, "reg_sum_0101_1010", 8'b0000_1111);
        expect_val(T_C4, "reg_carry_0101_1010", 8'b0000_0000);
`endif

        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
